// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch queue between the fetch unit and decode.
// Holds up to 2**DEPTH_W records of DATA_W bits, in push order.
// A global ready (rdy_in) freezes the queue and flush_in empties it.
// Optional build macro FQ_BYPASS_EN lets a record offered to an empty queue
// pass straight to the consumer in the same cycle without being stored.
module fetch_queue #(
   parameter int unsigned DATA_W    = 88,
   parameter int unsigned DEPTH_W   = 4,
   parameter int unsigned AFULL_LVL = 2
) (
   input  logic               clk_in,
   input  logic               rst_in,
   input  logic               rdy_in,
   input  logic               flush_in,
   input  logic               in_valid,
   input  logic [DATA_W-1:0]  in_data,
   output logic               in_ready,
   output logic               out_valid,
   output logic [DATA_W-1:0]  out_data,
   input  logic               out_ready,
   output logic [DEPTH_W:0]   count,
   output logic               almost_full
);

   localparam int unsigned      DEPTH   = 2 ** DEPTH_W;
   localparam logic [DEPTH_W:0] DEPTH_C = {1'b1, {DEPTH_W{1'b0}}};
   localparam logic [DEPTH_W:0] ZERO_C  = {(DEPTH_W+1){1'b0}};
   localparam logic [DEPTH_W:0] ONE_C   = {{DEPTH_W{1'b0}}, 1'b1};
   localparam logic [DEPTH_W-1:0] PTR_ONE_C = {{(DEPTH_W-1){1'b0}}, 1'b1};

   logic [DATA_W-1:0]  mem_r [DEPTH];
   logic [DEPTH_W-1:0] wr_ptr_r;
   logic [DEPTH_W-1:0] rd_ptr_r;
   logic [DEPTH_W:0]   count_r;
   logic [DEPTH_W:0]   count_nxt_s;
   logic [DEPTH_W:0]   free_s;
   logic               empty_s;
   logic               full_s;
   logic               run_s;
   logic               byp_s;
   logic               push_s;
   logic               pop_s;
   logic               wr_en_s;
   logic               rd_en_s;

   // The queue only moves while out of reset, globally ready and not flushing.
   assign run_s   = rst_in && rdy_in && !flush_in;
   assign empty_s = (count_r == ZERO_C);
   assign full_s  = (count_r == DEPTH_C);
   assign free_s  = DEPTH_C - count_r;

`ifdef FQ_BYPASS_EN
   assign byp_s = run_s && empty_s && in_valid && out_ready;
`else
   assign byp_s = 1'b0;
`endif

   // in_ready deliberately does not look at out_ready, so a full queue stalls
   // the producer even if the consumer is popping this cycle.
   assign in_ready    = run_s && !full_s;
   assign out_valid   = run_s && (!empty_s || byp_s);
   assign push_s      = in_valid && in_ready;
   assign pop_s       = out_valid && out_ready;
   // A bypassed record completes both handshakes without touching storage.
   assign wr_en_s     = push_s && !byp_s;
   assign rd_en_s     = pop_s && !byp_s;
   assign count       = count_r;
   assign almost_full = ({{(31-DEPTH_W){1'b0}}, free_s} <= AFULL_LVL);

   // Head record is shown whenever something is stored so it holds steady
   // through a pause; a bypassed record is shown when the queue is empty.
   always_comb begin
      out_data = {DATA_W{1'b0}};
      if (!empty_s) begin
         out_data = mem_r[rd_ptr_r];
      end else if (byp_s) begin
         out_data = in_data;
      end else begin
         out_data = {DATA_W{1'b0}};
      end
   end

   // Next occupancy from the real storage write/read enables.
   always_comb begin
      count_nxt_s = count_r;
      case ({wr_en_s, rd_en_s})
         2'b10:   count_nxt_s = count_r + ONE_C;
         2'b01:   count_nxt_s = count_r - ONE_C;
         2'b11:   count_nxt_s = count_r;
         default: count_nxt_s = count_r;
      endcase
   end

   // Pointer and occupancy state; flush wins over everything but reset.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         wr_ptr_r <= {DEPTH_W{1'b0}};
         rd_ptr_r <= {DEPTH_W{1'b0}};
         count_r  <= ZERO_C;
      end else if (flush_in) begin
         wr_ptr_r <= {DEPTH_W{1'b0}};
         rd_ptr_r <= {DEPTH_W{1'b0}};
         count_r  <= ZERO_C;
      end else begin
         if (wr_en_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
         end
         if (rd_en_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
         end
         count_r <= count_nxt_s;
      end
   end

   // Record storage; contents need no reset because count gates visibility.
   always_ff @(posedge clk_in) begin
      if (wr_en_s) begin
         mem_r[wr_ptr_r] <= in_data;
      end
   end

endmodule
